// File: rtl/bcd_digit_scanner.sv
// bcd_digit_scanner
//   Time-multiplexes a packed word of NUM_DIGITS BCD digits onto one 4-bit BCD bus for a
//   downstream BCD-to-7-segment decoder, with a matching one-hot digit select.
//   Leading zeros can optionally be blanked by driving BLANK_CODE.
//
// Ports:
//   CLK        system clock, rising edge
//   RST        asynchronous active-high reset
//   LOAD       capture DIGITS into the shadow register on this edge
//   DIGITS     packed BCD, digit i = DIGITS[4i+3:4i], digit 0 least significant
//   BLANK_LZ   enable leading-zero blanking
//   BCD        code of the selected digit (registered)
//   DIGIT_SEL  one-hot active-high digit enable (registered)
//   SCAN_TICK  one-cycle pulse on each digit advance (registered)
module bcd_digit_scanner #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 50000,
  parameter logic [3:0]  BLANK_CODE = 4'b1111
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      LOAD,
  input  logic [4*NUM_DIGITS-1:0]   DIGITS,
  input  logic                      BLANK_LZ,
  output logic [3:0]                BCD,
  output logic [NUM_DIGITS-1:0]     DIGIT_SEL,
  output logic                      SCAN_TICK
);

  localparam int unsigned PrescW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IdxW   = $clog2(NUM_DIGITS);
  localparam logic [PrescW-1:0] PrescMax = PrescW'(SCAN_DIV - 1);
  localparam logic [IdxW-1:0]   IdxMax   = IdxW'(NUM_DIGITS - 1);

  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [PrescW-1:0]       presc_q, presc_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [3:0]              bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;
  logic                    tick_q, tick_d;

  logic                    advance;
  logic [4*NUM_DIGITS-1:0] src;
  logic [3:0]              src_digit [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   blank_vec;
  logic                    zero_above;

  always_comb begin
    advance = (presc_q == PrescMax);
    presc_d = advance ? '0 : presc_q + PrescW'(1);

    idx_d = idx_q;
    if (advance) begin
      idx_d = (idx_q == IdxMax) ? '0 : idx_q + IdxW'(1);
    end

    // Bypass the shadow so a LOAD is visible on BCD after exactly one edge.
    src      = LOAD ? DIGITS : shadow_q;
    shadow_d = src;

    // Walk from the most significant digit down; a digit is blanked only while every
    // digit at or above it is zero. Codes A-F count as nonzero.
    zero_above = 1'b1;
    blank_vec  = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      src_digit[i] = src[4*i +: 4];
      zero_above   = zero_above & (src[4*i +: 4] == 4'h0);
      blank_vec[i] = BLANK_LZ & zero_above & (i != 0);
    end

    sel_d        = '0;
    sel_d[idx_d] = 1'b1;
    bcd_d        = blank_vec[idx_d] ? BLANK_CODE : src_digit[idx_d];
    tick_d       = advance;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shadow_q <= '0;
      presc_q  <= '0;
      idx_q    <= '0;
      bcd_q    <= 4'b0000;
      sel_q    <= NUM_DIGITS'(1);
      tick_q   <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      bcd_q    <= bcd_d;
      sel_q    <= sel_d;
      tick_q   <= tick_d;
    end
  end

  assign BCD       = bcd_q;
  assign DIGIT_SEL = sel_q;
  assign SCAN_TICK = tick_q;

endmodule

// File: tb/tb_bcd_digit_scanner.sv
// Scoreboard bench for bcd_digit_scanner (NUM_DIGITS=4, SCAN_DIV=4).
// The stimulus process pushes the expected post-edge outputs; a monitor pops and compares.
module tb_bcd_digit_scanner;

  localparam int unsigned ND  = 4;
  localparam int unsigned DIV = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          LOAD;
  logic [15:0]   DIGITS;
  logic          BLANK_LZ;
  logic [3:0]    BCD;
  logic [ND-1:0] DIGIT_SEL;
  logic          SCAN_TICK;

  bcd_digit_scanner #(
    .NUM_DIGITS (ND),
    .SCAN_DIV   (DIV),
    .BLANK_CODE (4'b1111)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .LOAD      (LOAD),
    .DIGITS    (DIGITS),
    .BLANK_LZ  (BLANK_LZ),
    .BCD       (BCD),
    .DIGIT_SEL (DIGIT_SEL),
    .SCAN_TICK (SCAN_TICK)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0] bcd;
    logic [3:0] sel;
    logic       tick;
    logic [7:0] edge_n;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          pops   = 0;
  int unsigned m      = 0;       // edges since last reset release
  logic [15:0] shadow = '0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: after edge n the selected digit is (n / DIV) % ND, ticking on multiples of DIV.
  function automatic exp_t model(input int unsigned n, input logic [15:0] v, input logic blz);
    exp_t        e;
    int unsigned idx;
    logic [15:0] upper;
    idx      = (n / DIV) % ND;
    upper    = v >> (4 * idx);
    e.bcd    = (blz && idx > 0 && upper == 16'h0) ? 4'hF : upper[3:0];
    e.sel    = 4'(1 << idx);
    e.tick   = (n % DIV) == 0;
    e.edge_n = 8'(n);
    return e;
  endfunction

  // Drive one cycle of inputs, predict the next edge, then wait for the following negedge.
  task automatic step(input logic ld, input logic [15:0] d, input logic blz);
    logic [15:0] v;
    LOAD     = ld;
    DIGITS   = d;
    BLANK_LZ = blz;
    v        = ld ? d : shadow;
    m++;
    exp_q.push_back(model(m, v, blz));
    shadow = v;
    @(negedge CLK);
  endtask

  task automatic hold(input int n, input logic blz);
    for (int i = 0; i < n; i++) step(1'b0, 16'($urandom), blz);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " bcd"}, 16'(BCD), 16'h0);
    check({tag, " sel"}, 16'(DIGIT_SEL), 16'h1);
    check({tag, " tick"}, 16'(SCAN_TICK), 16'h0);
  endtask

  // Monitor: outputs are registered, so one response per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (!RST && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        pops++;
        check($sformatf("bcd edge %0d", e.edge_n), 16'(BCD), 16'(e.bcd));
        check($sformatf("sel edge %0d", e.edge_n), 16'(DIGIT_SEL), 16'(e.sel));
        check($sformatf("tick edge %0d", e.edge_n), 16'(SCAN_TICK), 16'(e.tick));
      end
    end
  end

  initial begin
    logic [15:0] rv;
    int unsigned nz;
    RST      = 1'b1;
    LOAD     = 1'bx;
    DIGITS   = 'x;
    BLANK_LZ = 1'bx;
    #1;
    check_reset_outputs("por");
    @(negedge CLK);
    RST = 1'b0;
    m = 0;
    shadow = '0;

    step(1'b0, 16'hFFFF, 1'b0);            // shadow still 0 -> digit 0 shows 0
    step(1'b1, 16'h1234, 1'b0);            // one-edge LOAD latency
    hold(16, 1'b0);

    // LOAD on the edge that advances from idx 0 to idx 1
    while (((m + 1) % (DIV * ND)) != DIV) step(1'b0, 16'h0000, 1'b0);
    step(1'b1, 16'h9876, 1'b0);
    hold(8, 1'b0);

    step(1'b1, 16'h0070, 1'b1); hold(16, 1'b1);
    step(1'b1, 16'h0000, 1'b1); hold(16, 1'b1);
    step(1'b1, 16'h0305, 1'b1); hold(16, 1'b1);
    hold(16, 1'b0);                        // blanking off: digit 3 shows 0
    step(1'b1, 16'h00A5, 1'b1); hold(16, 1'b1);

    // Async reset while idx=2 and the prescaler is at 1
    while ((m % (DIV * ND)) != 9) step(1'b0, 16'h0000, 1'b1);
    #2;
    RST = 1'b1;
    #1;
    check_reset_outputs("mid-scan rst");
    exp_q.delete();
    repeat (2) @(negedge CLK);
    check_reset_outputs("held rst");
    RST = 1'b0;
    m = 0;
    shadow = '0;
    hold(DIV + 2, 1'b0);

    for (int i = 0; i < 300; i++) begin
      nz = $urandom_range(0, 4);
      rv = 16'($urandom) & 16'((32'h1 << (4 * nz)) - 1);
      step(($urandom_range(0, 3) == 0), rv, 1'($urandom));
    end

    @(posedge CLK);
    #2;
    check("queue drained", 16'(exp_q.size()), 16'h0);
    if (pops < 400) begin
      checks++;
      errors++;
      $display("FAIL monitor pops: got %0d required at least 400", pops);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
